// File: rtl/sl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sl_pkg : shared default widths and tracker entry type for the sl root arbiter.
// Rev 1.0
// -----------------------------------------------------------------------------
package sl_pkg;

  localparam int SL_ADDR_WIDTH = 16;
  localparam int SL_DATA_WIDTH = 32;
  localparam int SL_ID_WIDTH   = 4;

  typedef struct packed {
    logic                   valid;
    logic [SL_ID_WIDTH-1:0] id;
  } trk_entry_t;

endpackage
`default_nettype wire

// File: rtl/sl_rr2.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sl_rr2 : two-way round-robin arbiter with a single favour pointer.
// Rev 1.0
// -----------------------------------------------------------------------------
module sl_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    // No grants while reset is asserted.
    if (rst_n) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sl_root_arb.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sl_root_arb : round-robin root arbiter for two masters with ID tagging,
// read-response steering and a fixed-latency response tracker. Rev 1.0
// -----------------------------------------------------------------------------
module sl_root_arb
  import sl_pkg::*;
#(
  parameter int ADDR_WIDTH = SL_ADDR_WIDTH,
  parameter int DATA_WIDTH = SL_DATA_WIDTH,
  parameter int ID_WIDTH   = SL_ID_WIDTH,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_wen,
  input  logic [ADDR_WIDTH-1:0] m0_waddr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [ID_WIDTH-2:0]   m0_wtag,
  output logic                  m0_wready,
  input  logic                  m0_ren,
  input  logic [ADDR_WIDTH-1:0] m0_raddr,
  input  logic [ID_WIDTH-2:0]   m0_rtag,
  output logic                  m0_rready,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [ID_WIDTH-2:0]   m0_rid,
  input  logic                  m1_wen,
  input  logic [ADDR_WIDTH-1:0] m1_waddr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [ID_WIDTH-2:0]   m1_wtag,
  output logic                  m1_wready,
  input  logic                  m1_ren,
  input  logic [ADDR_WIDTH-1:0] m1_raddr,
  input  logic [ID_WIDTH-2:0]   m1_rtag,
  output logic                  m1_rready,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ID_WIDTH-2:0]   m1_rid,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ID_WIDTH-1:0]   wid,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ID_WIDTH-1:0]   rid,
  input  logic                  rvalid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [ID_WIDTH-1:0]   id,
  output logic                  err_unexp,
  output logic                  err_miss,
  output logic                  err_id
);

  localparam int TAG_WIDTH = ID_WIDTH - 1;

  logic [1:0] wgnt;
  logic [1:0] rgnt;

  sl_rr2 u_rr_w (.clk(clk), .rst_n(rst_n), .req_i({m1_wen, m0_wen}), .gnt_o(wgnt));
  sl_rr2 u_rr_r (.clk(clk), .rst_n(rst_n), .req_i({m1_ren, m0_ren}), .gnt_o(rgnt));

  assign m0_wready = wgnt[0];
  assign m1_wready = wgnt[1];
  assign m0_rready = rgnt[0];
  assign m1_rready = rgnt[1];

  logic                  wen_q, ren_q;
  logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ID_WIDTH-1:0]   wid_q, rid_q;

  // A grant implies a request, so the grant vector is the accept vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wid_q   <= '0;
      ren_q   <= 1'b0;
      raddr_q <= '0;
      rid_q   <= '0;
    end else begin
      wen_q <= |wgnt;
      ren_q <= |rgnt;
      if (wgnt[1]) begin
        waddr_q <= m1_waddr;
        wdata_q <= m1_wdata;
        wid_q   <= {1'b1, m1_wtag};
      end else if (wgnt[0]) begin
        waddr_q <= m0_waddr;
        wdata_q <= m0_wdata;
        wid_q   <= {1'b0, m0_wtag};
      end
      if (rgnt[1]) begin
        raddr_q <= m1_raddr;
        rid_q   <= {1'b1, m1_rtag};
      end else if (rgnt[0]) begin
        raddr_q <= m0_raddr;
        rid_q   <= {1'b0, m0_rtag};
      end
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign wid   = wid_q;
  assign ren   = ren_q;
  assign raddr = raddr_q;
  assign rid   = rid_q;

  // Entry 0 is the head; an issued read reaches it exactly LATENCY cycles later.
  trk_entry_t trk_q [LATENCY];
  trk_entry_t tail;
  trk_entry_t head;

  always_comb begin
    tail       = '0;
    tail.valid = ren_q;
    tail.id    = SL_ID_WIDTH'(rid_q);
    head       = trk_q[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        trk_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY - 1; i++) begin
        trk_q[i] <= trk_q[i+1];
      end
      trk_q[LATENCY-1] <= tail;
    end
  end

  logic err_unexp_q, err_miss_q, err_id_q;
  logic m0_rvalid_q, m1_rvalid_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic [TAG_WIDTH-1:0]  m0_rid_q, m1_rid_q;
  logic to_m0, to_m1;

  assign to_m0 = rvalid & ~id[ID_WIDTH-1];
  assign to_m1 = rvalid &  id[ID_WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_unexp_q <= 1'b0;
      err_miss_q  <= 1'b0;
      err_id_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rid_q    <= '0;
      m1_rid_q    <= '0;
    end else begin
      err_miss_q  <= err_miss_q  | (head.valid & ~rvalid);
      err_unexp_q <= err_unexp_q | (~head.valid & rvalid);
      err_id_q    <= err_id_q    | (head.valid & rvalid & (head.id != SL_ID_WIDTH'(id)));
      m0_rvalid_q <= to_m0;
      m1_rvalid_q <= to_m1;
      if (to_m0) begin
        m0_rdata_q <= rdata;
        m0_rid_q   <= id[TAG_WIDTH-1:0];
      end
      if (to_m1) begin
        m1_rdata_q <= rdata;
        m1_rid_q   <= id[TAG_WIDTH-1:0];
      end
    end
  end

  assign err_unexp = err_unexp_q;
  assign err_miss  = err_miss_q;
  assign err_id    = err_id_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_rid    = m0_rid_q;
  assign m1_rid    = m1_rid_q;

endmodule
`default_nettype wire

// File: tb/tb_sl_root_arb.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sl_root_arb : randomized scoreboard bench for sl_root_arb with a root
// memory responder. Rev 1.0
// -----------------------------------------------------------------------------
module tb_sl_root_arb;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int TW  = IW - 1;
  localparam int LAT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    b_wen = '0;
  logic [1:0]    b_ren = '0;
  logic [AW-1:0] b_waddr [2];
  logic [DW-1:0] b_wdata [2];
  logic [TW-1:0] b_wtag  [2];
  logic [AW-1:0] b_raddr [2];
  logic [TW-1:0] b_rtag  [2];
  logic [1:0]    wready, rready, mrvalid;
  logic [DW-1:0] mrdata [2];
  logic [TW-1:0] mrid   [2];
  logic          wen, ren;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;
  logic [IW-1:0] wid, rid;
  logic          root_rvalid = 1'b0;
  logic [DW-1:0] root_rdata  = '0;
  logic [IW-1:0] root_id     = '0;
  logic          err_unexp, err_miss, err_id;

  sl_root_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_wen(b_wen[0]), .m0_waddr(b_waddr[0]), .m0_wdata(b_wdata[0]), .m0_wtag(b_wtag[0]),
    .m0_wready(wready[0]),
    .m0_ren(b_ren[0]), .m0_raddr(b_raddr[0]), .m0_rtag(b_rtag[0]), .m0_rready(rready[0]),
    .m0_rvalid(mrvalid[0]), .m0_rdata(mrdata[0]), .m0_rid(mrid[0]),
    .m1_wen(b_wen[1]), .m1_waddr(b_waddr[1]), .m1_wdata(b_wdata[1]), .m1_wtag(b_wtag[1]),
    .m1_wready(wready[1]),
    .m1_ren(b_ren[1]), .m1_raddr(b_raddr[1]), .m1_rtag(b_rtag[1]), .m1_rready(rready[1]),
    .m1_rvalid(mrvalid[1]), .m1_rdata(mrdata[1]), .m1_rid(mrid[1]),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wid(wid),
    .ren(ren), .raddr(raddr), .rid(rid),
    .rvalid(root_rvalid), .rdata(root_rdata), .id(root_id),
    .err_unexp(err_unexp), .err_miss(err_miss), .err_id(err_id)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [IW-1:0] id; } wexp_t;
  typedef struct { logic [AW-1:0] addr; logic [IW-1:0] id; } rexp_t;
  typedef struct { int due; logic [DW-1:0] data; logic [TW-1:0] tag; } mexp_t;
  typedef struct { int due; logic [DW-1:0] data; logic [IW-1:0] id; } rsp_t;

  wexp_t wq [$];
  rexp_t rq [$];
  mexp_t mq0 [$];
  mexp_t mq1 [$];
  rsp_t  rs [$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int wptr   = 0;
  int rptr   = 0;
  int rsp_delay = LAT;
  bit rsp_id_ovr = 1'b0;
  logic [IW-1:0] rsp_id_val = '0;
  bit rsp_fix = 1'b0;
  logic [DW-1:0] rsp_fix_data = '0;
  bit auto_exp = 1'b1;
  logic [1:0] wgot = '0;
  logic [1:0] rgot = '0;

  // Root memory contents as seen by the responder: a fixed function of the address.
  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return {a ^ 16'hBEEF, a};
  endfunction

  function automatic int pick(input logic [1:0] req, input int ptr);
    if (req == 2'b11) return ptr;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
    cyc++;
    root_rvalid = 1'b0;
    if (rs.size() > 0 && rs[0].due == cyc) begin
      root_rvalid = 1'b1;
      root_rdata  = rs[0].data;
      root_id     = rs[0].id;
      rs.delete(0);
    end
  endtask

  task automatic arb_check();
    int gw, gr;
    wexp_t we;
    rexp_t re;
    mexp_t me;
    #1;
    gw = rst_n ? pick(b_wen, wptr) : -1;
    gr = rst_n ? pick(b_ren, rptr) : -1;
    for (int m = 0; m < 2; m++) begin
      chk("wready", wready[m], gw == m);
      chk("rready", rready[m], gr == m);
    end
    wgot = '0;
    rgot = '0;
    if (gw >= 0) begin
      we.addr = b_waddr[gw];
      we.data = b_wdata[gw];
      we.id   = {gw[0], b_wtag[gw]};
      wq.push_back(we);
      wptr = 1 - gw;
      wgot[gw] = 1'b1;
    end
    if (gr >= 0) begin
      re.addr = b_raddr[gr];
      re.id   = {gr[0], b_rtag[gr]};
      rq.push_back(re);
      if (auto_exp) begin
        me.due  = cyc + LAT + 2;
        me.data = rsp_fix ? rsp_fix_data : fdat(b_raddr[gr]);
        me.tag  = b_rtag[gr];
        if (gr == 0) mq0.push_back(me);
        else         mq1.push_back(me);
      end
      rptr = 1 - gr;
      rgot[gr] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cycle_start();
      b_wen = '0;
      b_ren = '0;
      arb_check();
    end
  endtask

  task automatic apply_reset();
    cycle_start();
    rst_n = 1'b0;
    b_wen = '0;
    b_ren = '0;
    arb_check();
    cycle_start();
    rst_n = 1'b1;
    wptr = 0;
    rptr = 0;
    rsp_delay = LAT;
    rsp_id_ovr = 1'b0;
    rsp_fix = 1'b0;
    auto_exp = 1'b1;
    arb_check();
  endtask

  task automatic rand_reqs();
    for (int m = 0; m < 2; m++) begin
      if (!(b_wen[m] && !wgot[m])) begin
        b_wen[m]   = ($urandom_range(0, 3) != 0);
        b_waddr[m] = AW'($urandom);
        b_wdata[m] = $urandom;
        b_wtag[m]  = TW'($urandom);
      end
      if (!(b_ren[m] && !rgot[m])) begin
        b_ren[m]   = ($urandom_range(0, 4) > 1);
        b_raddr[m] = AW'($urandom);
        b_rtag[m]  = TW'($urandom);
      end
    end
  endtask

  task automatic check_drained();
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("mq0_empty", mq0.size(), 0);
    chk("mq1_empty", mq1.size(), 0);
    chk("rs_empty", rs.size(), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  wexp_t mon_w;
  rexp_t mon_r;
  mexp_t mon_m;
  rsp_t  mon_s;

  always @(negedge clk) begin
    if (wen === 1'b1) begin
      if (wq.size() == 0) chk("root_wen_unexpected", wen, 0);
      else begin
        mon_w = wq.pop_front();
        chk("root_waddr", waddr, mon_w.addr);
        chk("root_wdata", wdata, mon_w.data);
        chk("root_wid", wid, mon_w.id);
      end
    end
    if (ren === 1'b1) begin
      if (rq.size() == 0) chk("root_ren_unexpected", ren, 0);
      else begin
        mon_r = rq.pop_front();
        chk("root_raddr", raddr, mon_r.addr);
        chk("root_rid", rid, mon_r.id);
      end
      mon_s.due  = cyc + rsp_delay;
      mon_s.data = rsp_fix ? rsp_fix_data : fdat(raddr);
      mon_s.id   = rsp_id_ovr ? rsp_id_val : rid;
      rs.push_back(mon_s);
    end
    if (mrvalid !== 2'b00) chk("rvalid_onehot", mrvalid == 2'b11, 0);
    if (mrvalid[0] === 1'b1) begin
      if (mq0.size() == 0) chk("m0_rvalid_unexpected", mrvalid[0], 0);
      else begin
        mon_m = mq0.pop_front();
        chk("m0_resp_cycle", cyc, mon_m.due);
        chk("m0_rdata", mrdata[0], mon_m.data);
        chk("m0_rid", mrid[0], mon_m.tag);
      end
    end
    if (mrvalid[1] === 1'b1) begin
      if (mq1.size() == 0) chk("m1_rvalid_unexpected", mrvalid[1], 0);
      else begin
        mon_m = mq1.pop_front();
        chk("m1_resp_cycle", cyc, mon_m.due);
        chk("m1_rdata", mrdata[1], mon_m.data);
        chk("m1_rid", mrid[1], mon_m.tag);
      end
    end
    if (mq0.size() > 0 && mq0[0].due < cyc) begin
      chk("m0_resp_missing", cyc, mq0[0].due);
      mq0.delete(0);
    end
    if (mq1.size() > 0 && mq1[0].due < cyc) begin
      chk("m1_resp_missing", cyc, mq1[0].due);
      mq1.delete(0);
    end
  end

  initial begin
    int a;
    int d;
    for (int m = 0; m < 2; m++) begin
      b_waddr[m] = '0; b_wdata[m] = '0; b_wtag[m] = '0;
      b_raddr[m] = '0; b_rtag[m]  = '0;
    end

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", wen, 0);
    chk("rst_ren", ren, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wid", wid, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_rid", rid, 0);
    chk("rst_mrvalid", mrvalid, 0);
    chk("rst_mrdata0", mrdata[0], 0);
    chk("rst_mrdata1", mrdata[1], 0);
    chk("rst_mrid", {mrid[1], mrid[0]}, 0);
    chk("rst_errs", {err_unexp, err_miss, err_id}, 0);
    cycle_start();
    rst_n = 1'b1;
    arb_check();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle_start();
      rand_reqs();
      arb_check();
    end
    idle(LAT + 6);
    check_drained();
    chk("random_no_errs", {err_unexp, err_miss, err_id}, 0);

    // Single read with a fixed response word
    apply_reset();
    rsp_fix = 1'b1;
    rsp_fix_data = 32'hDEADBEEF;
    cycle_start();
    b_ren = 2'b01;
    b_raddr[0] = 16'h0010;
    b_rtag[0] = 3'd3;
    arb_check();
    idle(LAT + 4);
    chk("single_no_errs", {err_unexp, err_miss, err_id}, 0);
    check_drained();

    // Write contention: grants alternate starting with master 0
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cycle_start();
      b_wen = 2'b11;
      for (int m = 0; m < 2; m++) begin
        b_waddr[m] = AW'($urandom);
        b_wdata[m] = $urandom;
        b_wtag[m]  = TW'($urandom);
      end
      arb_check();
      chk("contention_grant", wready, (i % 2 == 1) ? 2'b10 : 2'b01);
    end
    idle(3);

    // Concurrent write from m1 and read from m0
    apply_reset();
    cycle_start();
    b_wen = 2'b10;
    b_waddr[1] = 16'h0020;
    b_wdata[1] = 32'h55;
    b_ren = 2'b01;
    b_raddr[0] = AW'($urandom);
    b_rtag[0] = 3'd6;
    arb_check();
    chk("concurrent_grants", {wready[1], rready[0]}, 2'b11);
    cycle_start();
    b_wen = '0;
    b_ren = '0;
    arb_check();
    @(negedge clk);
    chk("concurrent_fire", {wen, ren}, 2'b11);
    idle(LAT + 4);
    check_drained();

    // Late response: one cycle beyond LATENCY
    apply_reset();
    rsp_delay = LAT + 1;
    auto_exp = 1'b0;
    cycle_start();
    b_ren = 2'b01;
    b_raddr[0] = AW'($urandom);
    b_rtag[0] = 3'd2;
    arb_check();
    a = cyc;
    mq0.push_back('{a + LAT + 3, fdat(b_raddr[0]), 3'd2});
    for (int k = 0; k < LAT + 5; k++) begin
      cycle_start();
      b_ren = '0;
      arb_check();
      @(negedge clk);
      d = cyc - a;
      if (d == LAT + 2) begin
        chk("late_miss", err_miss, 1);
        chk("late_unexp_not_yet", err_unexp, 0);
      end
      if (d == LAT + 3) begin
        chk("late_unexp", err_unexp, 1);
        chk("late_miss_sticky", err_miss, 1);
      end
      if (d == LAT + 5) chk("late_sticky", {err_unexp, err_miss, err_id}, 3'b110);
    end
    check_drained();

    // Wrong ID: m1 issues rid 0x9, root answers with id 0x1
    apply_reset();
    rsp_id_ovr = 1'b1;
    rsp_id_val = 4'h1;
    auto_exp = 1'b0;
    cycle_start();
    b_ren = 2'b10;
    b_raddr[1] = AW'($urandom);
    b_rtag[1] = 3'd1;
    arb_check();
    a = cyc;
    mq0.push_back('{a + LAT + 2, fdat(b_raddr[1]), 3'd1});
    for (int k = 0; k < LAT + 3; k++) begin
      cycle_start();
      b_ren = '0;
      arb_check();
      @(negedge clk);
      d = cyc - a;
      if (d == LAT + 2) begin
        chk("wrongid_err", {err_unexp, err_miss, err_id}, 3'b001);
        chk("wrongid_steer", mrvalid, 2'b01);
      end
    end
    check_drained();

    // Reset two cycles after the root read issues
    apply_reset();
    cycle_start();
    b_ren = 2'b01;
    b_raddr[0] = AW'($urandom);
    b_rtag[0] = 3'd5;
    arb_check();
    a = cyc;
    idle(2);
    cycle_start();
    rst_n = 1'b0;
    arb_check();
    cycle_start();
    rst_n = 1'b1;
    wptr = 0;
    rptr = 0;
    arb_check();
    @(negedge clk);
    chk("midrst_root", {wen, ren, raddr, rid}, 0);
    chk("midrst_outs", {mrvalid, err_unexp, err_miss, err_id}, 0);
    for (int k = 0; k < 3; k++) begin
      cycle_start();
      arb_check();
      @(negedge clk);
      d = cyc - a;
      if (d == LAT + 2) chk("midrst_unexp", {err_unexp, err_miss, err_id}, 3'b100);
    end
    idle(LAT + 2);
    check_drained();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
